reg32_shift_out: RTL and testbench
==================================

REG32_SHIFT_OUT -- requirements
Module: reg32_shift_out

Interface
REQ-001 The block SHALL have one parameter: DIV, default 1, clock cycles per serial bit; legal range 1..255.
REQ-002 The block SHALL have port clk, input, 1 bit: the sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have port clear, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request to capture D and begin serialisation.
REQ-005 The block SHALL have port D, input, 32 bits: parallel word to transmit.
REQ-006 The block SHALL have port sout, output, 1 bit: serial data bit.
REQ-007 The block SHALL have port busy, output, 1 bit: high while bits are being shifted out.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse after the last bit period.

Function
REQ-009 The state machine SHALL have the states IDLE, SHIFT and DONE.
REQ-010 In IDLE, start=1 at a rising edge SHALL capture D into a 32-bit shift register, clear the bit and period counters, and enter SHIFT.
REQ-011 In SHIFT, busy SHALL be 1 and sout SHALL drive the current first-order bit (MSB by default) starting in the first SHIFT cycle.
REQ-012 Each bit SHALL be held for exactly DIV cycles (period counter 0..DIV-1); at period wrap the register SHALL shift one place and the 5-bit bit counter SHALL increment.
REQ-013 When the bit counter wraps from 31 with the period counter at DIV-1, the block SHALL enter DONE, so SHIFT lasts exactly 32*DIV cycles.
REQ-014 In DONE, done SHALL be 1 and busy SHALL be 0 for exactly one cycle, then the block SHALL return to IDLE unconditionally.
REQ-015 In IDLE and DONE, sout SHALL be 0.
REQ-016 start asserted in SHIFT or DONE SHALL be ignored; it is not queued.
REQ-017 start held high continuously SHALL begin a new frame on the first IDLE edge after DONE, giving one idle cycle between frames.
REQ-018 Changes on D after capture SHALL NOT affect the frame in progress.
REQ-019 Vacated shift-register positions SHALL fill with 0.

Reset
REQ-020 While clear=1, the state SHALL be IDLE and sout, busy and done SHALL be 0; the shift register and both counters SHALL be 0.
REQ-021 clear asserted mid-frame SHALL abort the frame immediately without a done pulse.
REQ-022 The first start is honoured on the first rising edge after clear deasserts.

Configuration
REQ-023 With macro SHIFT_LSB_FIRST_EN defined, bits SHALL be sent D[0] first through D[31] last, with right shifts.
REQ-024 Without SHIFT_LSB_FIRST_EN, bits SHALL be sent D[31] first through D[0] last, with left shifts.
REQ-025 All timing SHALL be identical in both configurations.

Structure
REQ-026 A shared package SHALL hold the state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2), the word width constant 32 and the bit counter width 5.
REQ-027 The period counter SHALL be a sub-module bit_timer (inputs clk, clear, run; output tick), with tick high on the last cycle of each bit period.

Verification
REQ-028 DIV=1, D=32'hA5A5_0F0F, one-cycle start: sout SHALL follow 1,0,1,0,0,1,0,1,... over 32 cycles; busy is high for 32 cycles; done pulses once on cycle 33.
REQ-029 DIV=4, D=32'h8000_0001: sout SHALL be high for the first 4 cycles, low for 120 cycles, then high for the last 4 cycles; done comes at 129 cycles.
REQ-030 With SHIFT_LSB_FIRST_EN, DIV=1, D=32'h0000_0001: sout SHALL be 1 in the first cycle only.
REQ-031 start pulsed at cycle 10 of a frame and D changed to 32'hFFFF_FFFF mid-frame: the output SHALL be unchanged and no second frame starts.
REQ-032 clear asserted at cycle 7 of a DIV=1 frame: all outputs SHALL be 0 immediately, with no done pulse; start then begins a clean frame.
REQ-033 start held high, DIV=2: consecutive frames SHALL be separated by one DONE cycle and one IDLE cycle.

Source files
------------

// File: rtl/reg32_shift_out_pkg.sv
// Shared types, widths and bit-order helpers for reg32_shift_out.
// Bit order is selected by SHIFT_LSB_FIRST_EN (undefined: MSB first, left shifts).
package reg32_shift_out_pkg;

  localparam int WORD_W    = 32;
  localparam int BIT_CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Bit currently presented on the serial line.
  function automatic logic first_bit(input logic [WORD_W-1:0] w);
`ifdef SHIFT_LSB_FIRST_EN
    return w[0];
`else
    return w[WORD_W-1];
`endif
  endfunction

  // Advance the word by one place, zero-filling the vacated end.
  function automatic logic [WORD_W-1:0] shift_one(input logic [WORD_W-1:0] w);
`ifdef SHIFT_LSB_FIRST_EN
    return {1'b0, w[WORD_W-1:1]};
`else
    return {w[WORD_W-2:0], 1'b0};
`endif
  endfunction

endpackage

// File: rtl/reg32_shift_out_bit_timer.sv
// Bit-period counter: counts 0..DIV-1 while run is high, tick on the last cycle.
// Held at zero whenever run is low so every frame starts on a fresh period.
module bit_timer #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam logic [7:0] LAST = 8'(DIV - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!run) begin
      cnt_d = 8'd0;
    end else if (cnt_q == LAST) begin
      cnt_d = 8'd0;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = run && (cnt_q == LAST);

endmodule

// File: rtl/reg32_shift_out.sv
// 32-bit parallel-in serial-out transmitter, DIV clocks per bit, IDLE/SHIFT/DONE FSM.
// Define SHIFT_LSB_FIRST_EN to send D[0] first; default sends D[31] first.
module reg32_shift_out
  import reg32_shift_out_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              start,
  input  logic [WORD_W-1:0] D,
  output logic              sout,
  output logic              busy,
  output logic              done
);

  state_e                 state_q, state_d;
  logic [WORD_W-1:0]      shreg_q, shreg_d;
  logic [BIT_CNT_W-1:0]   bitcnt_q, bitcnt_d;
  logic                   sout_q, sout_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   tick;

  bit_timer #(.DIV(DIV)) u_timer (
    .clk   (clk),
    .clear (clear),
    .run   (state_q == SHIFT),
    .tick  (tick)
  );

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          shreg_d  = D;
          bitcnt_d = 5'd0;
          state_d  = SHIFT;
        end else begin
          state_d  = IDLE;
        end
      end
      SHIFT: begin
        if (tick) begin
          shreg_d  = shift_one(shreg_q);
          bitcnt_d = bitcnt_q + 5'd1;
          if (bitcnt_q == 5'd31) begin
            state_d = DONE;
          end else begin
            state_d = SHIFT;
          end
        end else begin
          state_d = SHIFT;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they can be registered without lag.
    sout_d = (state_d == SHIFT) ? first_bit(shreg_d) : 1'b0;
    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      bitcnt_q <= 5'd0;
      sout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      sout_q   <= sout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign sout = sout_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_reg32_shift_out.sv
// Directed bench for reg32_shift_out with DIV=1, 2 and 4 instances sharing clk/clear.
module tb_reg32_shift_out;

  logic        clk = 1'b0;
  logic        clear;
  logic        start1, start2, start4;
  logic [31:0] d1, d2, d4;
  logic        sout1, busy1, done1;
  logic        sout2, busy2, done2;
  logic        sout4, busy4, done4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  reg32_shift_out #(.DIV(1)) u1 (.clk(clk), .clear(clear), .start(start1), .D(d1),
                                 .sout(sout1), .busy(busy1), .done(done1));
  reg32_shift_out #(.DIV(2)) u2 (.clk(clk), .clear(clear), .start(start2), .D(d2),
                                 .sout(sout2), .busy(busy2), .done(done2));
  reg32_shift_out #(.DIV(4)) u4 (.clk(clk), .clear(clear), .start(start4), .D(d4),
                                 .sout(sout4), .busy(busy4), .done(done4));

  function automatic logic exp_bit(input logic [31:0] w, input int k);
`ifdef SHIFT_LSB_FIRST_EN
    return w[k];
`else
    return w[31-k];
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {sout, busy, done} of the instance with the given DIV
  function automatic logic [2:0] outs(input int div);
    case (div)
      1:       return {sout1, busy1, done1};
      2:       return {sout2, busy2, done2};
      default: return {sout4, busy4, done4};
    endcase
  endfunction

  // Called at a negedge; returns at the negedge of the first SHIFT cycle.
  task automatic launch(input int div, input logic [31:0] w);
    case (div)
      1:       begin start1 = 1'b1; d1 = w; end
      2:       begin start2 = 1'b1; d2 = w; end
      default: begin start4 = 1'b1; d4 = w; end
    endcase
    @(negedge clk);
    start1 = 1'b0; start2 = 1'b0; start4 = 1'b0;
  endtask

  // Checks a whole frame from SHIFT cycle 1 through DONE; returns at the following negedge.
  task automatic frame_check(input int div, input logic [31:0] w, input string tag);
    for (int k = 0; k < 32; k++) begin
      for (int p = 0; p < div; p++) begin
        chk({tag, "_shift"}, {29'd0, outs(div)}, {29'd0, exp_bit(w, k), 1'b1, 1'b0});
        @(negedge clk);
      end
    end
    chk({tag, "_done"}, {29'd0, outs(div)}, 32'd1);
    @(negedge clk);
    chk({tag, "_idle"}, {29'd0, outs(div)}, 32'd0);
  endtask

  initial begin
    clear = 1'b1;
    start1 = 1'b0; start2 = 1'b0; start4 = 1'b0;
    d1 = 32'd0; d2 = 32'd0; d4 = 32'd0;
    repeat (3) @(negedge clk);
    chk("reset_u1", {29'd0, outs(1)}, 32'd0);
    chk("reset_u2", {29'd0, outs(2)}, 32'd0);
    chk("reset_u4", {29'd0, outs(4)}, 32'd0);

    // First start honoured on the first edge after clear drops.
    clear = 1'b0;
    launch(1, 32'hA5A5_0F0F);
    chk("a5_first_bits", {31'd0, sout1}, {31'd0, exp_bit(32'hA5A5_0F0F, 0)});
    frame_check(1, 32'hA5A5_0F0F, "a5a50f0f_div1");

    // DIV=4, D=8000_0001: high 4, low 120, high 4, done at cycle 129.
    launch(4, 32'h8000_0001);
    for (int c = 0; c < 128; c++) begin
      chk("div4_sout", {31'd0, sout4}, {31'd0, (c < 4 || c >= 124)});
      chk("div4_busy", {31'd0, busy4}, 32'd1);
      @(negedge clk);
    end
    chk("div4_done", {29'd0, outs(4)}, 32'd1);
    @(negedge clk);
    chk("div4_after", {29'd0, outs(4)}, 32'd0);

    // D=0000_0001 single set bit: first cycle with LSB-first, last cycle with MSB-first.
    launch(1, 32'h0000_0001);
    for (int c = 0; c < 32; c++) begin
`ifdef SHIFT_LSB_FIRST_EN
      chk("one_bit", {31'd0, sout1}, {31'd0, (c == 0)});
`else
      chk("one_bit", {31'd0, sout1}, {31'd0, (c == 31)});
`endif
      @(negedge clk);
    end
    chk("one_bit_done", {29'd0, outs(1)}, 32'd1);
    @(negedge clk);

    // start and D disturbed mid-frame must not change the frame or queue another.
    launch(1, 32'h1234_5678);
    for (int c = 0; c < 32; c++) begin
      chk("ignore_sout", {31'd0, sout1}, {31'd0, exp_bit(32'h1234_5678, c)});
      if (c == 10) begin start1 = 1'b1; d1 = 32'hFFFF_FFFF; end
      else begin start1 = 1'b0; end
      @(negedge clk);
    end
    chk("ignore_done", {29'd0, outs(1)}, 32'd1);
    @(negedge clk);
    chk("ignore_idle1", {29'd0, outs(1)}, 32'd0);
    @(negedge clk);
    chk("ignore_idle2", {29'd0, outs(1)}, 32'd0);

    // clear at cycle 7 aborts immediately with no done pulse.
    launch(1, 32'hFFFF_FFFF);
    for (int c = 0; c < 7; c++) begin
      chk("abort_pre", {29'd0, outs(1)}, 32'd6);
      @(negedge clk);
    end
    clear = 1'b1;
    #1;
    chk("abort_now", {29'd0, outs(1)}, 32'd0);
    @(negedge clk);
    chk("abort_hold", {29'd0, outs(1)}, 32'd0);
    clear = 1'b0;
    launch(1, 32'hC000_0003);
    frame_check(1, 32'hC000_0003, "after_abort");

    // start held high at DIV=2: one DONE and one IDLE cycle between frames.
    start2 = 1'b1; d2 = 32'hF000_0000;
    @(negedge clk);
    for (int c = 0; c < 64; c++) begin
      chk("held_sout", {31'd0, sout2}, {31'd0, exp_bit(32'hF000_0000, c / 2)});
      chk("held_busy", {30'd0, busy2, done2}, 32'd2);
      @(negedge clk);
    end
    chk("held_done", {29'd0, outs(2)}, 32'd1);
    @(negedge clk);
    chk("held_gap", {29'd0, outs(2)}, 32'd0);
    @(negedge clk);
    chk("held_restart", {29'd0, outs(2)}, {29'd0, exp_bit(32'hF000_0000, 0), 1'b1, 1'b0});
    start2 = 1'b0;
    clear = 1'b1;
    @(negedge clk);
    chk("final_clear", {29'd0, outs(2)}, 32'd0);
    clear = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
